// File: rtl/rom_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : rom_port_arbiter
// Purpose  : Shares one single-port program-ROM RAM between the HPS download
//            writer, main-CPU fetch and sound-CPU fetch. Also owns rom_loaded
//            and the core reset stretch. Optional macro ROM_ARB_CPU_PRIO_EN
//            selects fixed CPU priority instead of round-robin.
// Revision : 1.0 - initial release
// =============================================================================
module rom_port_arbiter #(
   parameter int              AW         = 16,
   parameter int              DW         = 8,
   parameter logic [AW-1:0]   SND_BASE   = 16'h8000,
   parameter logic [15:0]     RST_CYCLES = 16'hFFFF
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [24:0]   dl_addr,
   input  logic [DW-1:0] dl_data,
   input  logic          soft_reset,
   input  logic          cpu_req,
   input  logic [AW-2:0] cpu_addr,
   output logic [DW-1:0] cpu_data,
   output logic          cpu_valid,
   input  logic          snd_req,
   input  logic [AW-3:0] snd_addr,
   output logic [DW-1:0] snd_data,
   output logic          snd_valid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q,
   output logic          rom_loaded,
   output logic          core_reset
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_WRITE     = 2'd1;
   localparam logic [1:0] c_READ_ADDR = 2'd2;
   localparam logic [1:0] c_READ_DATA = 2'd3;

   localparam logic c_GNT_CPU = 1'b0;
   localparam logic c_GNT_SND = 1'b1;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          r_gnt;
   logic          w_gnt;

   logic [AW-1:0] r_ram_addr,  w_ram_addr_nxt;
   logic          r_ram_we,    w_ram_we_nxt;
   logic [DW-1:0] r_ram_d,     w_ram_d_nxt;
   logic [DW-1:0] r_cpu_data,  w_cpu_data_nxt;
   logic          r_cpu_valid, w_cpu_valid_nxt;
   logic [DW-1:0] r_snd_data,  w_snd_data_nxt;
   logic          r_snd_valid, w_snd_valid_nxt;
   logic          w_gnt_nxt;

   logic          r_dl_active_d;
   logic          r_rom_loaded;
   logic [15:0]   r_hold_cnt;
   logic          r_core_reset;

   logic          w_dl_in_range;
   logic          w_wr_start;
   logic          w_rd_start;
   logic          w_dl_fall;
   logic [AW-1:0] w_cpu_ram_addr;
   logic [AW-1:0] w_snd_ram_addr;

   assign w_dl_in_range  = (dl_addr[24:AW] == '0);
   assign w_wr_start     = (r_state == c_IDLE) && dl_active && dl_wr && w_dl_in_range;
   assign w_rd_start     = (r_state == c_IDLE) && !dl_active && (cpu_req || snd_req);
   assign w_cpu_ram_addr = {1'b0, cpu_addr};
   // Sound region wraps within the RAM if SND_BASE + snd_addr overflows.
   assign w_snd_ram_addr = SND_BASE + {2'b00, snd_addr};
   assign w_dl_fall      = r_dl_active_d && !dl_active;

`ifdef ROM_ARB_CPU_PRIO_EN
   always_comb begin
      w_gnt = cpu_req ? c_GNT_CPU : c_GNT_SND;
   end
`else
   logic r_last_grant;

   always_comb begin
      w_gnt = c_GNT_CPU;
      if (cpu_req && snd_req) begin
         w_gnt = (r_last_grant == c_GNT_CPU) ? c_GNT_SND : c_GNT_CPU;
      end else if (snd_req) begin
         w_gnt = c_GNT_SND;
      end
   end

   // Reset to SND so the CPU wins the first contended grant.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= c_GNT_SND;
      end else if (w_rd_start) begin
         r_last_grant <= w_gnt;
      end
   end
`endif

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_wr_start) begin
               w_state_nxt = c_WRITE;
            end else if (w_rd_start) begin
               w_state_nxt = c_READ_ADDR;
            end
         end
         c_WRITE:     w_state_nxt = c_IDLE;
         c_READ_ADDR: w_state_nxt = c_READ_DATA;
         c_READ_DATA: w_state_nxt = c_IDLE;
         default:     w_state_nxt = c_IDLE;
      endcase
   end

   // Output logic: next values of the registered RAM and requester outputs
   always_comb begin
      w_ram_addr_nxt  = r_ram_addr;
      w_ram_we_nxt    = 1'b0;
      w_ram_d_nxt     = r_ram_d;
      w_cpu_data_nxt  = r_cpu_data;
      w_cpu_valid_nxt = 1'b0;
      w_snd_data_nxt  = r_snd_data;
      w_snd_valid_nxt = 1'b0;
      w_gnt_nxt       = r_gnt;
      case (r_state)
         c_IDLE: begin
            if (w_wr_start) begin
               w_ram_addr_nxt = dl_addr[AW-1:0];
               w_ram_d_nxt    = dl_data;
               w_ram_we_nxt   = 1'b1;
            end else if (w_rd_start) begin
               w_ram_addr_nxt = (w_gnt == c_GNT_SND) ? w_snd_ram_addr : w_cpu_ram_addr;
               w_gnt_nxt      = w_gnt;
            end
         end
         c_READ_DATA: begin
            if (r_gnt == c_GNT_SND) begin
               w_snd_data_nxt  = ram_q;
               w_snd_valid_nxt = 1'b1;
            end else begin
               w_cpu_data_nxt  = ram_q;
               w_cpu_valid_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_d     <= '0;
         r_cpu_data  <= '0;
         r_cpu_valid <= 1'b0;
         r_snd_data  <= '0;
         r_snd_valid <= 1'b0;
         r_gnt       <= c_GNT_CPU;
      end else begin
         r_ram_addr  <= w_ram_addr_nxt;
         r_ram_we    <= w_ram_we_nxt;
         r_ram_d     <= w_ram_d_nxt;
         r_cpu_data  <= w_cpu_data_nxt;
         r_cpu_valid <= w_cpu_valid_nxt;
         r_snd_data  <= w_snd_data_nxt;
         r_snd_valid <= w_snd_valid_nxt;
         r_gnt       <= w_gnt_nxt;
      end
   end

   // Load tracking and core reset stretch
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_dl_active_d <= 1'b0;
         r_rom_loaded  <= 1'b0;
         r_hold_cnt    <= '0;
         r_core_reset  <= 1'b1;
      end else begin
         r_dl_active_d <= dl_active;
         if (w_dl_fall) begin
            r_rom_loaded <= 1'b1;
         end
         if (w_dl_fall || soft_reset) begin
            r_hold_cnt <= RST_CYCLES;
         end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
         end
         r_core_reset <= !r_rom_loaded || dl_active || soft_reset || (r_hold_cnt != '0);
      end
   end

   assign ram_addr   = r_ram_addr;
   assign ram_we     = r_ram_we;
   assign ram_d      = r_ram_d;
   assign cpu_data   = r_cpu_data;
   assign cpu_valid  = r_cpu_valid;
   assign snd_data   = r_snd_data;
   assign snd_valid  = r_snd_valid;
   assign rom_loaded = r_rom_loaded;
   assign core_reset = r_core_reset;

endmodule
`default_nettype wire
